// File: rtl/gcd_pkg.sv
// Shared types and default parameters for the GCD engine arbiter.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } gcd_arb_state_e;

    localparam int GCD_XLEN    = 32;
    localparam int GCD_TIMEOUT = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW:0] sum_s;
    logic [IW:0] idx_s;
    logic        hit_s;

    // Walk the requests from ptr; the first hit wins and masks later ones.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sum_s = {1'b0, ptr} + (IW+1)'(i);
            idx_s = (sum_s >= (IW+1)'(NREQ)) ? (sum_s - (IW+1)'(NREQ)) : sum_s;
            hit_s = req[idx_s[IW-1:0]] & ~any;
            grant[idx_s[IW-1:0]] = grant[idx_s[IW-1:0]] | hit_s;
            grant_id = hit_s ? idx_s[IW-1:0] : grant_id;
            any      = any | hit_s;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD engine among NREQ requesters.
// Define GCD_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns an error response.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int XLEN    = GCD_XLEN,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [XLEN-1:0]      rsp_gcd_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 gcd_ld_o,
    output logic [XLEN-1:0]      gcd_a_o,
    output logic [XLEN-1:0]      gcd_b_o,
    input  logic                 gcd_ready_i,
    input  logic                 gcd_valid_i,
    input  logic [XLEN-1:0]      gcd_result_i
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_check
        $error("gcd_arbiter: NREQ must be 2..16 and TIMEOUT at least 1");
    end

    gcd_arb_state_e  state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;

    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   grant_id_s;
    logic            any_s;
    logic [NREQ-1:0] req_ready_s;
    logic [NREQ-1:0] rsp_valid_s;
    logic            ld_s;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_q + CW'(1);
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req      (req_valid_i),
        .ptr      (ptr_q),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .any      (any_s)
    );

    // Next-state, handshake and engine-load decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        req_ready_s = '0;
        rsp_valid_s = '0;
        ld_s        = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
        err_d       = err_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    req_ready_s = grant_s;
                    a_d         = req_a_i[grant_id_s*XLEN +: XLEN];
                    b_d         = req_b_i[grant_id_s*XLEN +: XLEN];
                    id_d        = grant_id_s;
                    ptr_d       = (grant_id_s == IW'(NREQ - 1)) ? '0 : (grant_id_s + IW'(1));
                    state_d     = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                // The engine may still be finishing a job dropped by reset; wait for it.
                if (gcd_ready_i) begin
                    ld_s    = 1'b1;
                    state_d = WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
            WAIT: begin
                if (gcd_valid_i) begin
                    res_d   = gcd_result_i;
                    state_d = RESP;
`ifdef GCD_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_inc_s == CW'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = WAIT;
                end
`else
                end else begin
                    state_d = WAIT;
                end
`endif
            end
            RESP: begin
                rsp_valid_s[id_q] = 1'b1;
                if (rsp_ready_i[id_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and job registers; reset drops any in-flight job.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    // Watchdog counter and error flag for the current job.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign rsp_err_o = (state_q == RESP) ? err_q : 1'b0;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Reset also masks the combinational accept so every output reads zero.
    assign req_ready_o = req_ready_s & {NREQ{~rst_i}};
    assign rsp_valid_o = rsp_valid_s;
    assign rsp_gcd_o   = (state_q == RESP) ? res_q : '0;
    assign busy_o      = (state_q != IDLE);
    assign gcd_ld_o    = ld_s;
    assign gcd_a_o     = a_q;
    assign gcd_b_o     = b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: randomized clients and engine against a transaction-level model.
module tb_gcd_arbiter;

    localparam int XLEN = 32;
    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [NREQ*XLEN-1:0] req_a_i, req_b_i;
    logic [XLEN-1:0]      rsp_gcd_o, gcd_a_o, gcd_b_o, gcd_result_i;
    logic                 rsp_err_o, busy_o, gcd_ld_o, gcd_ready_i, gcd_valid_i;

    always #5 clk = ~clk;

    gcd_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_gcd_o(rsp_gcd_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .gcd_ld_o(gcd_ld_o), .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
        .gcd_ready_i(gcd_ready_i), .gcd_valid_i(gcd_valid_i), .gcd_result_i(gcd_result_i)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pending client requests, one job in flight, stage 0 idle / 1 load / 2 engine / 3 response.
    logic [NREQ-1:0] pend;
    logic [XLEN-1:0] pa [NREQ];
    logic [XLEN-1:0] pb [NREQ];
    int              ptr_m, stage, job_id, wait_n, jobs_done;
    logic [XLEN-1:0] job_a, job_b, job_res;
    logic            job_err;
    // Engine model and stimulus knobs.
    logic            eng_busy, eng_dead;
    int              eng_cnt, stall_n, stall_len, bp_n, bp_len;
    logic [XLEN-1:0] eng_res;
    bit              rand_req, rand_rdy;
    int              grant_log [$];
    logic [XLEN-1:0] rsp_log [$];
    logic            err_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] gcd_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] p, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [XLEN-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return XLEN'($urandom_range(0, 3));
            1:       return XLEN'($urandom_range(1, 200));
            default: return XLEN'($urandom);
        endcase
    endfunction

    task automatic drive();
        req_valid_i = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_a_i[i*XLEN +: XLEN] = pa[i];
            req_b_i[i*XLEN +: XLEN] = pb[i];
        end
        gcd_ready_i = !eng_busy && (stall_n == 0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
        check_eq({tag, "_rsp_gcd"},   64'(rsp_gcd_o),   64'(0));
        check_eq({tag, "_rsp_err"},   64'(rsp_err_o),   64'(0));
        check_eq({tag, "_busy"},      64'(busy_o),      64'(0));
        check_eq({tag, "_ld"},        64'(gcd_ld_o),    64'(0));
        check_eq({tag, "_gcd_a"},     64'(gcd_a_o),     64'(0));
        check_eq({tag, "_gcd_b"},     64'(gcd_b_o),     64'(0));
    endtask

    task automatic model_reset();
        stage   = 0;
        ptr_m   = 0;
        stall_n = 0;
        bp_n    = 0;
        drive();
    endtask

    // One clock: compare at the falling edge, then advance the model and drive new inputs.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy, exp_rsp;
        logic            exp_ld, ev, hs;
        logic [XLEN-1:0] ev_res;
        int              g;
        @(negedge clk);
        g       = (stage == 0) ? rr_pick(pend, ptr_m) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_ld  = (stage == 1) && gcd_ready_i;
        exp_rsp = '0;
        if (stage == 3) exp_rsp[job_id] = 1'b1;
        check_eq("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        check_eq("gcd_ld",    64'(gcd_ld_o),    64'(exp_ld));
        check_eq("busy",      64'(busy_o),      64'(stage != 0));
        check_eq("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
        if (exp_ld) begin
            check_eq("gcd_a", 64'(gcd_a_o), 64'(job_a));
            check_eq("gcd_b", 64'(gcd_b_o), 64'(job_b));
        end
        if (stage == 3) begin
            check_eq("rsp_gcd", 64'(rsp_gcd_o), 64'(job_res));
            check_eq("rsp_err", 64'(rsp_err_o), 64'(job_err));
        end
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready_o[k]) grant_log.push_back(k);
        end
        ev     = gcd_valid_i;
        ev_res = gcd_result_i;
        hs     = (stage == 3) && rsp_ready_i[job_id];
        if (hs) begin
            rsp_log.push_back(rsp_gcd_o);
            err_last = rsp_err_o;
        end
        if (stage == 2) wait_n++;
        @(posedge clk);
        #1;
        if (stall_n > 0) stall_n--;
        gcd_valid_i = 1'b0;
        if (eng_busy) begin
            if (eng_cnt == 0) begin
                gcd_valid_i  = 1'b1;
                gcd_result_i = eng_res;
                eng_busy     = 1'b0;
            end else begin
                eng_cnt--;
            end
        end
        case (stage)
            0: if (g >= 0) begin
                job_id  = g;
                job_a   = pa[g];
                job_b   = pb[g];
                pend[g] = 1'b0;
                ptr_m   = (g + 1) % NREQ;
                stage   = 1;
                stall_n = (stall_len < 0) ? $urandom_range(0, 3) : stall_len;
            end
            1: if (exp_ld) begin
                stage  = 2;
                wait_n = 0;
                if (!eng_dead) begin
                    eng_busy = 1'b1;
                    eng_cnt  = $urandom_range(0, 5);
                    eng_res  = gcd_ref(job_a, job_b);
                end
            end
            2: if (ev) begin
                job_res = ev_res;
                job_err = 1'b0;
                stage   = 3;
                bp_n    = bp_len;
            end
`ifdef GCD_ARB_TIMEOUT_EN
            else if (wait_n == TMO) begin
                job_res = '0;
                job_err = 1'b1;
                stage   = 3;
                bp_n    = bp_len;
            end
`endif
            3: if (hs) begin
                stage = 0;
                jobs_done++;
            end
            default: stage = 0;
        endcase
        // Stray engine valids outside WAIT must be ignored.
        if (stage != 2 && !gcd_valid_i && $urandom_range(0, 7) == 0) begin
            gcd_valid_i  = 1'b1;
            gcd_result_i = XLEN'($urandom);
        end
        if (stage == 3 && bp_n > 0) begin
            rsp_ready_i         = NREQ'($urandom);
            rsp_ready_i[job_id] = 1'b0;
            bp_n--;
        end else if (rand_rdy) begin
            rsp_ready_i = NREQ'($urandom);
        end else begin
            rsp_ready_i = '1;
        end
        if (rand_req) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = rand_op();
                    pb[i]   = rand_op();
                end
            end
        end
        drive();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (jobs_done < target && n < budget) begin
            cycle();
            n++;
        end
        if (jobs_done < target) check_eq(tag, 64'(jobs_done), 64'(target));
    endtask

    task automatic pulse_reset(input string tag);
        rst_i = 1'b1;
        model_reset();
        @(negedge clk);
        check_zero(tag);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int n;
        int exp_res [4];
        rst_i = 1'b1;
        pend = '0; eng_busy = 1'b0; eng_dead = 1'b0; eng_cnt = 0; eng_res = '0;
        jobs_done = 0; wait_n = 0; job_id = 0; job_a = '0; job_b = '0;
        job_res = '0; job_err = 1'b0; err_last = 1'b0;
        stall_len = 0; bp_len = 0; rand_req = 1'b0; rand_rdy = 1'b0;
        gcd_valid_i = 1'b0; gcd_result_i = '0; rsp_ready_i = '0;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        model_reset();
        pulse_reset("reset");

        // Single request from client 0.
        pend[0] = 1'b1; pa[0] = 32'd34; pb[0] = 32'd289;
        drive();
        rsp_log.delete();
        run_until(jobs_done + 1, 100, "single_budget");
        check_eq("single_cnt", 64'(rsp_log.size()), 64'(1));
        if (rsp_log.size() >= 1) check_eq("single_gcd", 64'(rsp_log[0]), 64'(17));

        // All four at once from ptr=0, with response backpressure and a stalled engine.
        pulse_reset("reset2");
        pa[0] = 32'd34;   pb[0] = 32'd289;
        pa[1] = 32'd1701; pb[1] = 32'd199;
        pa[2] = 32'd48;   pb[2] = 32'd18;
        pa[3] = 32'd0;    pb[3] = 32'd7;
        exp_res = '{17, 1, 6, 7};
        pend = '1;
        bp_len = 10; stall_len = 5;
        drive();
        grant_log.delete();
        rsp_log.delete();
        run_until(jobs_done + 4, 400, "all4_budget");
        check_eq("all4_grants", 64'(grant_log.size()), 64'(4));
        check_eq("all4_rsps", 64'(rsp_log.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) check_eq("all4_order", 64'(grant_log[k]), 64'(k));
            if (k < rsp_log.size())   check_eq("all4_gcd", 64'(rsp_log[k]), 64'(exp_res[k]));
        end

        // Randomized traffic.
        bp_len = 0; stall_len = -1; rand_req = 1'b1; rand_rdy = 1'b1;
        run_until(jobs_done + 40, 4000, "random_budget");

        // Reset while a job is with the engine.
        n = 0;
        while (stage != 2 && n < 200) begin
            cycle();
            n++;
        end
        check_eq("reach_wait", 64'(stage), 64'(2));
        #2;
        rst_i = 1'b1;
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        run_until(jobs_done + 10, 1500, "post_reset_budget");

`ifdef GCD_ARB_TIMEOUT_EN
        // Dead engine: the watchdog must return an error response.
        rand_req = 1'b0;
        n = 0;
        while ((pend != '0 || stage != 0) && n < 2000) begin
            cycle();
            n++;
        end
        eng_dead = 1'b1;
        pend[1] = 1'b1; pa[1] = 32'd12; pb[1] = 32'd8;
        drive();
        run_until(jobs_done + 1, 200, "timeout_budget");
        check_eq("timeout_err", 64'(err_last), 64'(1));
        if (rsp_log.size() > 0) check_eq("timeout_gcd", 64'(rsp_log[rsp_log.size()-1]), 64'(0));
        eng_dead = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
